// File: rtl/noc_run_ctrl_if.sv
// ============================================================================
// Module   : noc_run_ctrl_if
// Purpose  : Host-side bundle for the NoC test-run sequencer: start/mode,
//            per-node finish flags and latency stats, plus noc_top control
//            and aggregate results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface noc_run_ctrl_if #(
  parameter int NODE_NUM = 9,
  parameter int TIME_W   = 10,
  parameter int SUM_W    = 28,
  parameter int TMO_W    = 16
);
  logic                       start;
  logic [3:0]                 run_mode;
  logic [NODE_NUM-1:0]        send_done;
  logic [NODE_NUM-1:0]        recv_done;
  logic [NODE_NUM*TIME_W-1:0] lat_min_in;
  logic [NODE_NUM*TIME_W-1:0] lat_max_in;
  logic [NODE_NUM*SUM_W-1:0]  lat_sum_in;
  logic                       enable_o;
  logic                       flush_o;
  logic [3:0]                 mode_o;
  logic                       busy;
  logic                       done;
  logic                       timeout_err;
  logic [TMO_W-1:0]           run_cycles;
  logic [TIME_W-1:0]          agg_min;
  logic [TIME_W-1:0]          agg_max;
  logic [SUM_W+3:0]           agg_sum;

  modport master (
    output start, run_mode, send_done, recv_done, lat_min_in, lat_max_in, lat_sum_in,
    input  enable_o, flush_o, mode_o, busy, done, timeout_err, run_cycles,
           agg_min, agg_max, agg_sum
  );

  modport slave (
    input  start, run_mode, send_done, recv_done, lat_min_in, lat_max_in, lat_sum_in,
    output enable_o, flush_o, mode_o, busy, done, timeout_err, run_cycles,
           agg_min, agg_max, agg_sum
  );
endinterface

`default_nettype wire

// File: rtl/noc_run_ctrl.sv
// ============================================================================
// Module   : noc_run_ctrl
// Purpose  : Flushes and enables the 3x3 NoC, waits for all nodes to finish
//            (or time out), then serially folds per-node latency stats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_run_ctrl #(
  parameter int               NODE_NUM  = 9,
  parameter int               TIME_W    = 10,
  parameter int               SUM_W     = 28,
  parameter int               TMO_W     = 16,
  parameter logic [TMO_W-1:0] TIMEOUT   = 16'hFFFF,
  parameter int               FLUSH_CYC = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  noc_run_ctrl_if.slave      bus
);

  localparam int                c_FCNT_W     = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int                c_IDX_W      = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;
  localparam logic [c_FCNT_W-1:0] c_FLUSH_LAST = c_FCNT_W'(FLUSH_CYC - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST   = c_IDX_W'(NODE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_SETTLE  = 3'd2,
    S_RUN     = 3'd3,
    S_COLLECT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              r_state;
  logic [c_FCNT_W-1:0] r_fcnt;
  logic [c_IDX_W-1:0]  r_idx;
  logic                r_enable;
  logic                r_flush;
  logic [3:0]          r_mode;
  logic                r_busy;
  logic                r_done;
  logic                r_tmo;
  logic [TMO_W-1:0]    r_run_cycles;
  logic [TIME_W-1:0]   r_agg_min;
  logic [TIME_W-1:0]   r_agg_max;
  logic [SUM_W+3:0]    r_agg_sum;

  logic                w_all_done;
  logic [TMO_W-1:0]    w_run_next;
  logic [TIME_W-1:0]   w_node_min;
  logic [TIME_W-1:0]   w_node_max;
  logic [SUM_W+3:0]    w_node_sum;

  assign w_all_done = &(bus.send_done & bus.recv_done);
  assign w_run_next = r_run_cycles + TMO_W'(1);
  assign w_node_min = bus.lat_min_in[r_idx*TIME_W +: TIME_W];
  assign w_node_max = bus.lat_max_in[r_idx*TIME_W +: TIME_W];
  assign w_node_sum = {4'b0000, bus.lat_sum_in[r_idx*SUM_W +: SUM_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_fcnt       <= '0;
      r_idx        <= '0;
      r_enable     <= 1'b0;
      r_flush      <= 1'b0;
      r_mode       <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tmo        <= 1'b0;
      r_run_cycles <= '0;
      r_agg_min    <= '1;
      r_agg_max    <= '0;
      r_agg_sum    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state      <= S_FLUSH;
            r_busy       <= 1'b1;
            r_flush      <= 1'b1;
            r_fcnt       <= c_FLUSH_LAST;
            r_mode       <= bus.run_mode;
            r_tmo        <= 1'b0;
            r_run_cycles <= '0;
            r_agg_min    <= '1;
            r_agg_max    <= '0;
            r_agg_sum    <= '0;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == '0) begin
            r_flush <= 1'b0;
            r_state <= S_SETTLE;
          end else begin
            r_fcnt <= r_fcnt - 1'b1;
          end
        end
        // One dead cycle so noc_top can drop stale finish flags before enable.
        S_SETTLE: begin
          r_enable <= 1'b1;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          r_run_cycles <= w_run_next;
          if (w_all_done) begin
            r_enable <= 1'b0;
            r_idx    <= '0;
            r_state  <= S_COLLECT;
          end else if (w_run_next == TIMEOUT) begin
            r_enable <= 1'b0;
            r_tmo    <= 1'b1;
            r_idx    <= '0;
            r_state  <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_node_min < r_agg_min) r_agg_min <= w_node_min;
          if (w_node_max > r_agg_max) r_agg_max <= w_node_max;
          r_agg_sum <= r_agg_sum + w_node_sum;
          if (r_idx == c_IDX_LAST) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.enable_o    = r_enable;
  assign bus.flush_o     = r_flush;
  assign bus.mode_o      = r_mode;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_tmo;
  assign bus.run_cycles  = r_run_cycles;
  assign bus.agg_min     = r_agg_min;
  assign bus.agg_max     = r_agg_max;
  assign bus.agg_sum     = r_agg_sum;

endmodule

`default_nettype wire
